// File: rtl/params_pkg.sv
// Shared bus widths, router FSM states and the default device-region map
// that the linker script mirrors.
package params_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } mmio_state_t;

  // Region field values (top nibble of the address) owned by each peripheral
  localparam logic [3:0] REGION_RAM    = 4'd0;
  localparam logic [3:0] REGION_ROM    = 4'd1;
  localparam logic [3:0] REGION_MATRIX = 4'd2;
  localparam logic [3:0] REGION_IRQ    = 4'd3;
  localparam logic [3:0] REGION_REGF   = 4'd4;
  localparam logic [3:0] REGION_EXEC   = 4'd5;
  localparam logic [3:0] REGION_SPI    = 4'd6;

endpackage

// File: rtl/mmio_region_dec.sv
// Combinational region decoder: region field plus enable mask to hit/index.
// A miss reports index N_DEV so the value can drive an "idle" ID directly.
module mmio_region_dec #(
  parameter int unsigned          N_DEV  = 7,
  parameter int unsigned          SEL_W  = 4,
  parameter logic [N_DEV-1:0]     DEV_EN = {N_DEV{1'b1}},
  parameter int unsigned          IDW    = $clog2(N_DEV + 1)
) (
  input  logic [SEL_W-1:0] region,
  output logic             hit,
  output logic [IDW-1:0]   idx
);

  always_comb begin
    hit = 1'b0;
    idx = IDW'(N_DEV);
    for (int unsigned i = 0; i < N_DEV; i++) begin
      if (region == SEL_W'(i) && DEV_EN[i]) begin
        hit = 1'b1;
        idx = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/mmio_router.sv
// Registered MMIO router: decodes the address region, runs a request/ready
// handshake with one device, enforces a timeout and records error status.
module mmio_router
  import params_pkg::*;
#(
  parameter int unsigned      N_DEV   = 7,
  parameter int unsigned      SEL_W   = 4,
  parameter logic [N_DEV-1:0] DEV_EN  = {N_DEV{1'b1}},
  parameter int unsigned      TIMEOUT = 16,
  parameter int unsigned      ERRC_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        m_rd,
  input  logic                        m_wr,
  input  logic [ADDR_W-1:0]           m_addr,
  input  logic [DATA_W-1:0]           m_wdata,
  output logic [DATA_W-1:0]           m_rdata,
  output logic                        m_ready,
  output logic                        m_err,
  output logic [N_DEV-1:0]            dev_sel,
  output logic                        dev_rd,
  output logic                        dev_wr,
  output logic [ADDR_W-1:0]           dev_addr,
  output logic [DATA_W-1:0]           dev_wdata,
  input  logic [N_DEV*DATA_W-1:0]     dev_rdata,
  input  logic [N_DEV-1:0]            dev_ready,
  output logic [$clog2(N_DEV+1)-1:0]  act_did,
  output logic [ADDR_W-1:0]           err_addr,
  output logic [ERRC_W-1:0]           err_cnt,
  input  logic                        err_clr
);

  localparam int unsigned IDW = $clog2(N_DEV + 1);
  localparam int unsigned TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  mmio_state_t state, state_n;

  logic [IDW-1:0]    idx, idx_n;
  logic [TW-1:0]     tcnt, tcnt_n;
  logic [N_DEV-1:0]  sel_n;
  logic              rd_n, wr_n, ready_n, err_n;
  logic [ADDR_W-1:0] addr_n, err_a, err_addr_n;
  logic [DATA_W-1:0] wdata_n, rdata_n;
  logic [IDW-1:0]    did_n;
  logic [ERRC_W-1:0] err_cnt_n;
  logic              err_ev;
  logic              hit;
  logic [IDW-1:0]    hit_idx;

  mmio_region_dec #(
    .N_DEV  (N_DEV),
    .SEL_W  (SEL_W),
    .DEV_EN (DEV_EN),
    .IDW    (IDW)
  ) u_dec (
    .region (m_addr[ADDR_W-1 -: SEL_W]),
    .hit    (hit),
    .idx    (hit_idx)
  );

  // Next-state logic also computes the next value of every output register,
  // so all outputs leave the block straight from flops.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    tcnt_n  = tcnt;
    sel_n   = dev_sel;
    rd_n    = dev_rd;
    wr_n    = dev_wr;
    addr_n  = dev_addr;
    wdata_n = dev_wdata;
    rdata_n = m_rdata;
    did_n   = act_did;
    ready_n = 1'b0;
    err_n   = 1'b0;
    err_ev  = 1'b0;
    err_a   = m_addr;

    unique case (state)
      S_IDLE: begin
        if (m_rd || m_wr) begin
          if ((m_rd ^ m_wr) && hit) begin
            state_n = S_ACCESS;
            idx_n   = hit_idx;
            tcnt_n  = '0;
            sel_n   = N_DEV'(1) << hit_idx;
            rd_n    = m_rd;
            wr_n    = m_wr;
            addr_n  = m_addr;
            wdata_n = m_wdata;
            did_n   = hit_idx;
          end else begin
            state_n = S_RESP;
            ready_n = 1'b1;
            err_n   = 1'b1;
            err_ev  = 1'b1;
            did_n   = IDW'(N_DEV);
          end
        end
      end

      S_ACCESS: begin
        if (dev_ready[idx]) begin
          state_n = S_RESP;
          ready_n = 1'b1;
          rdata_n = dev_rdata[idx*DATA_W +: DATA_W];
          sel_n   = '0;
          rd_n    = 1'b0;
          wr_n    = 1'b0;
          did_n   = IDW'(N_DEV);
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          state_n = S_RESP;
          ready_n = 1'b1;
          err_n   = 1'b1;
          err_ev  = 1'b1;
          err_a   = dev_addr;
          sel_n   = '0;
          rd_n    = 1'b0;
          wr_n    = 1'b0;
          did_n   = IDW'(N_DEV);
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
      end

      S_RESP: begin
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // A new error takes precedence over a same-cycle clear: count restarts at 1.
  always_comb begin
    err_cnt_n  = err_cnt;
    err_addr_n = err_addr;
    if (err_ev) begin
      err_addr_n = err_a;
      if (err_clr)       err_cnt_n = ERRC_W'(1);
      else if (&err_cnt) err_cnt_n = err_cnt;
      else               err_cnt_n = err_cnt + 1'b1;
    end else if (err_clr) begin
      err_cnt_n  = '0;
      err_addr_n = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      tcnt      <= '0;
      dev_sel   <= '0;
      dev_rd    <= 1'b0;
      dev_wr    <= 1'b0;
      dev_addr  <= '0;
      dev_wdata <= '0;
      m_rdata   <= '0;
      m_ready   <= 1'b0;
      m_err     <= 1'b0;
      act_did   <= IDW'(N_DEV);
      err_addr  <= '0;
      err_cnt   <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      tcnt      <= tcnt_n;
      dev_sel   <= sel_n;
      dev_rd    <= rd_n;
      dev_wr    <= wr_n;
      dev_addr  <= addr_n;
      dev_wdata <= wdata_n;
      m_rdata   <= rdata_n;
      m_ready   <= ready_n;
      m_err     <= err_n;
      act_did   <= did_n;
      err_addr  <= err_addr_n;
      err_cnt   <= err_cnt_n;
    end
  end

endmodule

// File: tb/tb_mmio_router.sv
// Directed bench for mmio_router with default parameters (7 devices, TIMEOUT=16).
module tb_mmio_router;
  import params_pkg::*;

  logic                 clk;
  logic                 rst;
  logic                 m_rd, m_wr;
  logic [ADDR_W-1:0]    m_addr;
  logic [DATA_W-1:0]    m_wdata;
  logic [DATA_W-1:0]    m_rdata;
  logic                 m_ready, m_err;
  logic [6:0]           dev_sel;
  logic                 dev_rd, dev_wr;
  logic [ADDR_W-1:0]    dev_addr;
  logic [DATA_W-1:0]    dev_wdata;
  logic [7*DATA_W-1:0]  dev_rdata;
  logic [6:0]           dev_ready;
  logic [2:0]           act_did;
  logic [ADDR_W-1:0]    err_addr;
  logic [7:0]           err_cnt;
  logic                 err_clr;

  int n_asrt = 0;
  int n_fail = 0;

  localparam logic [3:0] REGS [7] = '{REGION_RAM, REGION_ROM, REGION_MATRIX,
                                      REGION_IRQ, REGION_REGF, REGION_EXEC, REGION_SPI};

  mmio_router #(
    .N_DEV   (7),
    .SEL_W   (4),
    .DEV_EN  (7'b1111111),
    .TIMEOUT (16),
    .ERRC_W  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m_rd      (m_rd),
    .m_wr      (m_wr),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .m_ready   (m_ready),
    .m_err     (m_err),
    .dev_sel   (dev_sel),
    .dev_rd    (dev_rd),
    .dev_wr    (dev_wr),
    .dev_addr  (dev_addr),
    .dev_wdata (dev_wdata),
    .dev_rdata (dev_rdata),
    .dev_ready (dev_ready),
    .act_did   (act_did),
    .err_addr  (err_addr),
    .err_cnt   (err_cnt),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int hi;
    bit got;

    rst = 1'b1; m_rd = 1'b0; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
    dev_ready = '0; err_clr = 1'b0;
    for (int i = 0; i < 7; i++) dev_rdata[i*DATA_W +: DATA_W] = DATA_W'(16'hA000 + i);
    dev_rdata[1*DATA_W +: DATA_W] = 16'h1234;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_ready",  m_ready, 0);
    chk("rst_err",    m_err, 0);
    chk("rst_sel",    dev_sel, 0);
    chk("rst_did",    act_did, 7);
    chk("rst_errcnt", err_cnt, 0);
    chk("rst_rdata",  m_rdata, 0);

    // write 0x2040 / 0xBEEF, device 2 ready at once
    m_wr = 1'b1; m_addr = 16'h2040; m_wdata = 16'hBEEF;
    step();
    chk("w_sel",   dev_sel, 7'b0000100);
    chk("w_wr",    dev_wr, 1);
    chk("w_rd",    dev_rd, 0);
    chk("w_wdata", dev_wdata, 16'hBEEF);
    chk("w_addr",  dev_addr, 16'h2040);
    chk("w_did",   act_did, 2);
    chk("w_noack", m_ready, 0);
    dev_ready = 7'b0000100;
    step();
    chk("w_ready", m_ready, 1);
    chk("w_err",   m_err, 0);
    chk("w_seloff", dev_sel, 0);
    m_wr = 1'b0; dev_ready = '0;
    step();
    chk("w_pulse", m_ready, 0);

    // read 0x1000, device 1 inserts 3 waits; stray ready from device 6 ignored
    m_rd = 1'b1; m_addr = 16'h1000;
    step();
    chk("r_rd",  dev_rd, 1);
    chk("r_did", act_did, 1);
    dev_ready = 7'b1000000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("r_wait_ready", m_ready, 0);
      chk("r_wait_sel", dev_sel, 7'b0000010);
    end
    dev_ready = 7'b0000010;
    step();
    chk("r_ready", m_ready, 1);
    chk("r_err",   m_err, 0);
    chk("r_rdata", m_rdata, 16'h1234);
    m_rd = 1'b0; dev_ready = '0;
    step();

    // unmapped region 9
    m_rd = 1'b1; m_addr = 16'h9000;
    step();
    chk("u_ready",   m_ready, 1);
    chk("u_err",     m_err, 1);
    chk("u_sel",     dev_sel, 0);
    chk("u_rd",      dev_rd, 0);
    chk("u_erraddr", err_addr, 16'h9000);
    chk("u_errcnt",  err_cnt, 1);
    chk("u_did",     act_did, 7);
    m_rd = 1'b0;
    step();
    chk("u_pulse", m_ready, 0);

    // region 7 == N_DEV is also unmapped
    m_rd = 1'b1; m_addr = 16'h7000;
    step();
    chk("u7_err", m_err, 1);
    chk("u7_sel", dev_sel, 0);
    m_rd = 1'b0;
    step();

    // timeout on device 6
    m_rd = 1'b1; m_addr = 16'h6000;
    step();
    hi = 0; got = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_ready) begin
        got = 1;
        break;
      end
      if (dev_rd) hi++;
      step();
    end
    chk("t_got",     got, 1);
    chk("t_hi",      hi, 16);
    chk("t_err",     m_err, 1);
    chk("t_rd",      dev_rd, 0);
    chk("t_errcnt",  err_cnt, 3);
    chk("t_erraddr", err_addr, 16'h6000);
    m_rd = 1'b0;
    step();

    // illegal rd+wr
    m_rd = 1'b1; m_wr = 1'b1; m_addr = 16'h0000;
    step();
    chk("b_err",     m_err, 1);
    chk("b_ready",   m_ready, 1);
    chk("b_sel",     dev_sel, 0);
    chk("b_errcnt",  err_cnt, 4);
    chk("b_erraddr", err_addr, 0);
    m_rd = 1'b0; m_wr = 1'b0;
    step();

    // clear, then clear colliding with an error
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("c_errcnt",  err_cnt, 0);
    chk("c_erraddr", err_addr, 0);
    err_clr = 1'b1; m_rd = 1'b1; m_addr = 16'h8000;
    step();
    err_clr = 1'b0; m_rd = 1'b0;
    chk("cc_errcnt",  err_cnt, 1);
    chk("cc_erraddr", err_addr, 16'h8000);
    step();

    // saturation
    for (int j = 1; j <= 300; j++) begin
      m_rd = 1'b1; m_addr = 16'hF000;
      step();
      m_rd = 1'b0;
      step();
      if (j == 253) chk("s_254", err_cnt, 254);
    end
    chk("s_sat", err_cnt, 255);

    // every region routes to its own select line
    for (int i = 0; i < 7; i++) begin
      m_wr = 1'b1; m_addr = {REGS[i], 12'h010}; m_wdata = 16'h0F00;
      step();
      chk("map_sel", dev_sel, 32'(1) << i);
      dev_ready = 7'(1) << i;
      step();
      chk("map_ok", {m_ready, m_err}, 2'b10);
      m_wr = 1'b0; dev_ready = '0;
      step();
    end

    // asynchronous reset during ACCESS
    m_rd = 1'b1; m_addr = 16'h3000;
    step();
    chk("ar_pre", dev_rd, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_sel",    dev_sel, 0);
    chk("ar_rd",     dev_rd, 0);
    chk("ar_did",    act_did, 7);
    chk("ar_errcnt", err_cnt, 0);
    chk("ar_addr",   dev_addr, 0);
    m_rd = 1'b0;
    step(); step();
    chk("ar_noack", m_ready, 0);
    rst = 1'b0;
    step();
    m_wr = 1'b1; m_addr = 16'h4000; m_wdata = 16'h0055;
    step();
    chk("ar2_sel",   dev_sel, 7'b0010000);
    chk("ar2_wdata", dev_wdata, 16'h0055);
    dev_ready = 7'b0010000;
    step();
    chk("ar2_ok", {m_ready, m_err}, 2'b10);
    m_wr = 1'b0; dev_ready = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
